// File: rtl/rst_release_sequencer.sv
// Downstream reset-domain sequencer: holds every domain in reset, then releases
// them one at a time in index order, gated by per-domain acks with an optional timeout.
module rst_release_sequencer #(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned ASSERT_CYCLES  = 8,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] dom_ack,
  output logic [NUM_DOMAINS-1:0] rst_domain,
  output logic [NUM_DOMAINS-1:0] rstn_domain,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   timeout_err,
  output logic [3:0]             err_domain
);

  localparam int unsigned MAX_AG   = (ASSERT_CYCLES > GAP_CYCLES) ? ASSERT_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_MAX  = (MAX_AG > TIMEOUT_CYCLES) ? MAX_AG : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int unsigned LAST_IDX = NUM_DOMAINS - 1;
  localparam int unsigned TO_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          TO_EN    = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    ASSERT_ALL = 2'd0,
    GAP        = 2'd1,
    WAIT_ACK   = 2'd2,
    RUN        = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rdom_q, rdom_d;
  logic [NUM_DOMAINS-1:0] rstn_q;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   terr_q, terr_d;
  logic [3:0]             errd_q, errd_d;
  logic [NUM_DOMAINS-1:0] sel_mask;
  logic                   ack_sel;
  logic                   timed_out;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ASSERT_ALL;
      cnt_q   <= '0;
      idx_q   <= '0;
      rdom_q  <= '1;
      rstn_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      errd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rdom_q  <= rdom_d;
      rstn_q  <= ~rdom_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      errd_q  <= errd_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rdom_d    = rdom_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    terr_d    = terr_q;
    errd_d    = errd_q;
    sel_mask  = NUM_DOMAINS'(1) << idx_q;
    ack_sel   = |(dom_ack & sel_mask);
    timed_out = TO_EN && (cnt_q == CNT_W'(TO_LAST));

    case (state_q)
      ASSERT_ALL: begin
        rdom_d = '1;
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(ASSERT_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          rdom_d  = rdom_q & ~sel_mask;
          state_d = WAIT_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        // A timeout edge behaves exactly like an ack edge, plus the error record
        if (ack_sel || timed_out) begin
          if (!ack_sel) begin
            terr_d = 1'b1;
            errd_d = 4'(idx_q);
          end
          cnt_d = '0;
          if (idx_q == IDX_W'(LAST_IDX)) begin
            state_d = RUN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = GAP;
          end
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (sw_rst_req) begin
      state_d = ASSERT_ALL;
      cnt_d   = '0;
      idx_d   = '0;
      rdom_d  = '1;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      terr_d  = 1'b0;
      errd_d  = '0;
    end
  end

  assign rst_domain  = rdom_q;
  assign rstn_domain = rstn_q;
  assign seq_busy    = busy_q;
  assign seq_done    = done_q;
  assign timeout_err = terr_q;
  assign err_domain  = errd_q;

endmodule

// File: tb/tb_rst_release_sequencer.sv
// Directed bench for rst_release_sequencer: default 4-domain instance plus a
// single-domain, timeout-disabled instance.
module tb_rst_release_sequencer;

  logic       clk;
  logic       rst;
  logic       sw;
  logic [3:0] ack;
  logic [3:0] rd;
  logic [3:0] rn;
  logic       busy;
  logic       done;
  logic       terr;
  logic [3:0] errd;

  logic       rst1;
  logic [0:0] ack1;
  logic [0:0] rd1;
  logic [0:0] rn1;
  logic       busy1;
  logic       done1;
  logic       terr1;
  logic [3:0] errd1;
  logic       done1_seen = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  rst_release_sequencer u0 (
    .clk(clk), .rst(rst), .sw_rst_req(sw), .dom_ack(ack),
    .rst_domain(rd), .rstn_domain(rn), .seq_busy(busy), .seq_done(done),
    .timeout_err(terr), .err_domain(errd)
  );

  rst_release_sequencer #(.NUM_DOMAINS(1), .TIMEOUT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst1), .sw_rst_req(1'b0), .dom_ack(ack1),
    .rst_domain(rd1), .rstn_domain(rn1), .seq_busy(busy1), .seq_done(done1),
    .timeout_err(terr1), .err_domain(errd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done1) done1_seen <= 1'b1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp4;

  initial begin
    rst = 1'b1; rst1 = 1'b1; sw = 1'b0; ack = 4'h0; ack1 = 1'b0;

    // 1: nominal sequence, acks two cycles after each release
    step(3);
    chk("rst_rd",    rd, 4'hF);
    chk("rst_rn",    rn, 4'h0);
    chk("rst_busy",  4'(busy), 4'd1);
    chk("rst_done",  4'(done), 4'd0);
    chk("rst_terr",  4'(terr), 4'd0);
    chk("rst_errd",  errd, 4'd0);
    rst = 1'b0; rst1 = 1'b0;
    step(11);
    chk("t1_e11_rd",  rd, 4'hF);
    chk("t1_e11_rd1", 4'(rd1), 4'd1);
    step(1);
    chk("t1_e12_rd",  rd, 4'hE);
    chk("t1_e12_rn",  rn, 4'h1);
    chk("t1_e12_rd1", 4'(rd1), 4'd0);
    chk("t1_e12_rn1", 4'(rn1), 4'd1);
    for (int k = 0; k < 4; k++) begin
      step(1);
      ack[k] = 1'b1;
      if (k < 3) begin
        step(4);
        exp4 = 4'hF;
        exp4 = exp4 << (k + 1);
        chk("t1_hold_rd", rd, exp4);
        step(1);
        exp4 = 4'hF;
        exp4 = exp4 << (k + 2);
        chk("t1_rel_rd", rd, exp4);
      end else begin
        step(1);
        chk("t1_done",  4'(done), 4'd1);
        chk("t1_busy",  4'(busy), 4'd0);
        step(1);
        chk("t1_done2", 4'(done), 4'd0);
        chk("t1_busy2", 4'(busy), 4'd0);
      end
    end
    chk("t1_terr", 4'(terr), 4'd0);
    ack = 4'h0;
    step(3);
    chk("t1_run_rd",   rd, 4'h0);
    chk("t1_run_rn",   rn, 4'hF);
    chk("t1_run_busy", 4'(busy), 4'd0);

    // 2: acks held high throughout, spacing GAP+1
    rst = 1'b1; ack = 4'hF;
    step(2);
    rst = 1'b0;
    step(11); chk("t2_e11", rd, 4'hF);
    step(1);  chk("t2_e12", rd, 4'hE);
    step(4);  chk("t2_e16", rd, 4'hE);
    step(1);  chk("t2_e17", rd, 4'hC);
    step(5);  chk("t2_e22", rd, 4'h8);
    step(4);  chk("t2_e26", rd, 4'h8);
    step(1);  chk("t2_e27", rd, 4'h0);
    chk("t2_e27_busy", 4'(busy), 4'd1);
    chk("t2_e27_done", 4'(done), 4'd0);
    step(1);
    chk("t2_e28_done", 4'(done), 4'd1);
    chk("t2_e28_busy", 4'(busy), 4'd0);
    step(1);
    chk("t2_e29_done", 4'(done), 4'd0);

    // 3: domain 2 never acks, timeout after 64 edges
    rst = 1'b1; ack = 4'b1011;
    step(2);
    rst = 1'b0;
    step(22); chk("t3_e22", rd, 4'h8);
    step(63);
    chk("t3_e85_terr", 4'(terr), 4'd0);
    chk("t3_e85_rd",   rd, 4'h8);
    step(1);
    chk("t3_e86_terr", 4'(terr), 4'd1);
    chk("t3_e86_errd", errd, 4'd2);
    chk("t3_e86_busy", 4'(busy), 4'd1);
    step(3);  chk("t3_e89_rd", rd, 4'h8);
    step(1);  chk("t3_e90_rd", rd, 4'h0);
    step(1);
    chk("t3_e91_done", 4'(done), 4'd1);
    chk("t3_e91_busy", 4'(busy), 4'd0);
    chk("t3_e91_terr", 4'(terr), 4'd1);
    chk("t3_e91_errd", errd, 4'd2);

    // 4: software reset from RUN clears the error, then again mid-sequence
    sw = 1'b1;
    step(1);
    chk("t4_sw_rd",   rd, 4'hF);
    chk("t4_sw_rn",   rn, 4'h0);
    chk("t4_sw_busy", 4'(busy), 4'd1);
    chk("t4_sw_terr", 4'(terr), 4'd0);
    chk("t4_sw_errd", errd, 4'd0);
    step(1);
    sw = 1'b0; ack = 4'b0011;
    step(11); chk("t4_e11", rd, 4'hF);
    step(1);  chk("t4_e12", rd, 4'hE);
    step(10); chk("t4_e22", rd, 4'h8);
    step(8);
    chk("t4_e30_rd",   rd, 4'h8);
    chk("t4_e30_busy", 4'(busy), 4'd1);
    sw = 1'b1;
    step(1);
    chk("t4_mid_rd", rd, 4'hF);
    sw = 1'b0;
    step(11); chk("t4_re11", rd, 4'hF);
    step(1);  chk("t4_re12", rd, 4'hE);

    // 5: rst together with sw_rst_req while in GAP for domain 1
    step(2);
    chk("t5_gap_rd", rd, 4'hE);
    rst = 1'b1; sw = 1'b1;
    step(1);
    chk("t5_rd",   rd, 4'hF);
    chk("t5_rn",   rn, 4'h0);
    chk("t5_busy", 4'(busy), 4'd1);
    chk("t5_done", 4'(done), 4'd0);
    chk("t5_terr", 4'(terr), 4'd0);
    chk("t5_errd", errd, 4'd0);
    rst = 1'b0; sw = 1'b0;
    step(11); chk("t5_e11", rd, 4'hF);
    step(1);  chk("t5_e12", rd, 4'hE);

    // 6: single domain, no timeout, no ack: parked in WAIT_ACK
    chk("t6_rd1",   4'(rd1), 4'd0);
    chk("t6_rn1",   4'(rn1), 4'd1);
    chk("t6_busy1", 4'(busy1), 4'd1);
    chk("t6_done1", 4'(done1_seen), 4'd0);
    chk("t6_terr1", 4'(terr1), 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
